// File: rtl/register_bank_pkg.sv
// Shared types for the register bank: op encoding and swap sequencer states.
package register_bank_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    NOP  = 3'd0,
    LOAD = 3'd1,
    MOV  = 3'd2,
    INC  = 3'd3,
    DEC  = 3'd4,
    SWAP = 3'd5,
    PUSH = 3'd6,
    POP  = 3'd7
  } bank_op_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SWAP2 = 1'b1
  } swap_state_e;

endpackage

// File: rtl/register_bank_reg_stack.sv
// Small LIFO used to spill and restore bank registers; err is sticky until reset.
module reg_stack #(
  parameter int unsigned DATA_BUS_WIDTH = 8,
  parameter int unsigned STACK_DEPTH    = 4,
  localparam int unsigned SP_W          = $clog2(STACK_DEPTH + 1)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      push,
  input  logic                      pop,
  input  logic [DATA_BUS_WIDTH-1:0] push_data,
  output logic [DATA_BUS_WIDTH-1:0] top_data,
  output logic                      full,
  output logic                      empty,
  output logic                      err
);

  logic [DATA_BUS_WIDTH-1:0] mem [STACK_DEPTH];
  logic [SP_W-1:0]           sp;
  logic [SP_W-1:0]           top_idx;

  assign full    = (sp == SP_W'(STACK_DEPTH));
  assign empty   = (sp == '0);
  assign top_idx = sp - SP_W'(1);

  // Top-of-stack read; reads 0 when empty
  always_comb begin
    top_data = '0;
    for (int i = 0; i < int'(STACK_DEPTH); i++) begin
      if (!empty && top_idx == SP_W'(i)) top_data = mem[i];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sp  <= '0;
      err <= 1'b0;
      for (int i = 0; i < int'(STACK_DEPTH); i++) mem[i] <= '0;
    end else if (push) begin
      if (full) begin
        err <= 1'b1;
      end else begin
        for (int i = 0; i < int'(STACK_DEPTH); i++) begin
          if (sp == SP_W'(i)) mem[i] <= push_data;
        end
        sp <= sp + SP_W'(1);
      end
    end else if (pop) begin
      if (empty) err <= 1'b1;
      else       sp  <= top_idx;
    end
  end

endmodule

// File: rtl/register_bank.sv
// Parametrised register bank with two combinational read ports, in-place
// arithmetic, move, two-cycle swap and a spill/restore stack.
module register_bank
  import register_bank_pkg::*;
#(
  parameter int unsigned DATA_BUS_WIDTH = 8,
  parameter int unsigned NUM_REGS       = 4,
  parameter int unsigned STACK_DEPTH    = 4,
  localparam int unsigned SEL_W         = $clog2(NUM_REGS)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [OP_W-1:0]           op,
  input  logic [SEL_W-1:0]          wr_sel,
  input  logic [SEL_W-1:0]          src_sel,
  input  logic [SEL_W-1:0]          reg_1_out_sel,
  input  logic [SEL_W-1:0]          reg_2_out_sel,
  input  logic [DATA_BUS_WIDTH-1:0] reg_data_in,
  output logic [DATA_BUS_WIDTH-1:0] reg_1_out,
  output logic [DATA_BUS_WIDTH-1:0] reg_2_out,
  output logic                      busy,
  output logic                      stack_full,
  output logic                      stack_empty,
  output logic                      stack_err
);

  logic [DATA_BUS_WIDTH-1:0] regs [NUM_REGS];
  logic [DATA_BUS_WIDTH-1:0] tmp;
  logic [SEL_W-1:0]          lat_src;
  swap_state_e               state, state_d;

  logic [DATA_BUS_WIDTH-1:0] wr_val, src_val, top_data, wr_data;
  logic [SEL_W-1:0]          wr_idx;
  logic                      wr_en, tmp_en, push, pop;

  assign busy = (state == SWAP2);

  // Select decode; selects beyond NUM_REGS read as 0
  always_comb begin
    reg_1_out = '0;
    reg_2_out = '0;
    wr_val    = '0;
    src_val   = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (reg_1_out_sel == SEL_W'(i)) reg_1_out = regs[i];
      if (reg_2_out_sel == SEL_W'(i)) reg_2_out = regs[i];
      if (wr_sel        == SEL_W'(i)) wr_val    = regs[i];
      if (src_sel       == SEL_W'(i)) src_val   = regs[i];
    end
  end

  // Op decode and swap sequencer next state
  always_comb begin
    state_d = state;
    wr_en   = 1'b0;
    wr_idx  = wr_sel;
    wr_data = '0;
    tmp_en  = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        case (bank_op_e'(op))
          LOAD: begin wr_en = 1'b1; wr_data = reg_data_in; end
          MOV:  begin wr_en = 1'b1; wr_data = src_val; end
          INC:  begin wr_en = 1'b1; wr_data = wr_val + DATA_BUS_WIDTH'(1); end
          DEC:  begin wr_en = 1'b1; wr_data = wr_val - DATA_BUS_WIDTH'(1); end
          SWAP: begin
            wr_en   = 1'b1;
            wr_data = src_val;
            tmp_en  = 1'b1;
            state_d = SWAP2;
          end
          PUSH: push = 1'b1;
          POP: begin
            pop     = 1'b1;
            wr_en   = !stack_empty;
            wr_data = top_data;
          end
          default: ;
        endcase
      end
      SWAP2: begin
        wr_en   = 1'b1;
        wr_idx  = lat_src;
        wr_data = tmp;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  // Register array plus swap temporaries; out-of-range writes fall through
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tmp     <= '0;
      lat_src <= '0;
      for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
    end else begin
      if (tmp_en) begin
        tmp     <= wr_val;
        lat_src <= src_sel;
      end
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        if (wr_en && wr_idx == SEL_W'(i)) regs[i] <= wr_data;
      end
    end
  end

  reg_stack #(
    .DATA_BUS_WIDTH (DATA_BUS_WIDTH),
    .STACK_DEPTH    (STACK_DEPTH)
  ) u_stack (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (src_val),
    .top_data  (top_data),
    .full      (stack_full),
    .empty     (stack_empty),
    .err       (stack_err)
  );

endmodule

// File: tb/tb_register_bank.sv
// Bench for register_bank: a 4-register and a 3-register bank share stimulus
// and are compared against an array/stack reference model.
module tb_register_bank;
  import register_bank_pkg::*;

  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] op = 3'd0;
  logic [1:0] wr_sel = '0, src_sel = '0, s1 = '0, s2 = '0;
  logic [7:0] din = '0;

  logic [7:0] a_r1, a_r2, b_r1, b_r2;
  logic       a_busy, a_full, a_empty, a_err;
  logic       b_busy, b_full, b_empty, b_err;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: bank 0 has 4 registers, bank 1 has 3
  int         nr [2] = '{4, 3};
  logic [7:0] mreg [2][4];
  logic [7:0] mstk [2][DEPTH];
  int         msp [2];
  logic       merr [2];
  logic       mbusy [2];
  logic [7:0] mtmp [2];
  int         mlsrc [2];

  always #5 clock = ~clock;

  register_bank #(.DATA_BUS_WIDTH(8), .NUM_REGS(4), .STACK_DEPTH(DEPTH)) dut_a (
    .clock(clock), .reset(reset), .op(op), .wr_sel(wr_sel), .src_sel(src_sel),
    .reg_1_out_sel(s1), .reg_2_out_sel(s2), .reg_data_in(din),
    .reg_1_out(a_r1), .reg_2_out(a_r2), .busy(a_busy),
    .stack_full(a_full), .stack_empty(a_empty), .stack_err(a_err));

  register_bank #(.DATA_BUS_WIDTH(8), .NUM_REGS(3), .STACK_DEPTH(DEPTH)) dut_b (
    .clock(clock), .reset(reset), .op(op), .wr_sel(wr_sel), .src_sel(src_sel),
    .reg_1_out_sel(s1), .reg_2_out_sel(s2), .reg_data_in(din),
    .reg_1_out(b_r1), .reg_2_out(b_r2), .busy(b_busy),
    .stack_full(b_full), .stack_empty(b_empty), .stack_err(b_err));

  function automatic logic [7:0] rd(input int b, input int s);
    return (s < nr[b]) ? mreg[b][s] : 8'h00;
  endfunction

  task automatic wr(input int b, input int s, input logic [7:0] v);
    if (s < nr[b]) mreg[b][s] = v;
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 4; i++) mreg[b][i] = 8'h00;
      for (int i = 0; i < DEPTH; i++) mstk[b][i] = 8'h00;
      msp[b] = 0; merr[b] = 1'b0; mbusy[b] = 1'b0; mtmp[b] = 8'h00; mlsrc[b] = 0;
    end
  endtask

  // Effect of one rising edge given the currently driven inputs
  task automatic model_edge();
    int ws, ss;
    logic [7:0] v, t;
    ws = int'(wr_sel);
    ss = int'(src_sel);
    for (int b = 0; b < 2; b++) begin
      if (mbusy[b]) begin
        wr(b, mlsrc[b], mtmp[b]);
        mbusy[b] = 1'b0;
      end else begin
        case (op)
          3'd1: wr(b, ws, din);
          3'd2: wr(b, ws, rd(b, ss));
          3'd3: begin v = rd(b, ws) + 8'd1; wr(b, ws, v); end
          3'd4: begin v = rd(b, ws) - 8'd1; wr(b, ws, v); end
          3'd5: begin
            t = rd(b, ws);
            v = rd(b, ss);
            wr(b, ws, v);
            mtmp[b] = t; mlsrc[b] = ss; mbusy[b] = 1'b1;
          end
          3'd6: begin
            if (msp[b] == DEPTH) merr[b] = 1'b1;
            else begin mstk[b][msp[b]] = rd(b, ss); msp[b]++; end
          end
          3'd7: begin
            if (msp[b] == 0) merr[b] = 1'b1;
            else begin msp[b]--; wr(b, ws, mstk[b][msp[b]]); end
          end
          default: ;
        endcase
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("a_r1", a_r1, rd(0, int'(s1)));
    chk("a_r2", a_r2, rd(0, int'(s2)));
    chk("a_busy", 8'(a_busy), 8'(mbusy[0]));
    chk("a_full", 8'(a_full), 8'(msp[0] == DEPTH));
    chk("a_empty", 8'(a_empty), 8'(msp[0] == 0));
    chk("a_err", 8'(a_err), 8'(merr[0]));
    chk("b_r1", b_r1, rd(1, int'(s1)));
    chk("b_r2", b_r2, rd(1, int'(s2)));
    chk("b_busy", 8'(b_busy), 8'(mbusy[1]));
    chk("b_full", 8'(b_full), 8'(msp[1] == DEPTH));
    chk("b_empty", 8'(b_empty), 8'(msp[1] == 0));
    chk("b_err", 8'(b_err), 8'(merr[1]));
  endtask

  // Called at posedge+1: drive, check pre-edge state at negedge, advance model
  task automatic cycle(input logic [2:0] o, input int ws, input int ss,
                       input logic [7:0] d, input int r1, input int r2);
    op = o; wr_sel = 2'(ws); src_sel = 2'(ss); din = d; s1 = 2'(r1); s2 = 2'(r2);
    @(negedge clock);
    check_all();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  // Asynchronous reset asserted mid-cycle, released before the next edge
  task automatic do_reset();
    #2 reset = 1'b0;
    op = 3'd0;
    model_reset();
    #1 check_all();
    @(negedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    model_reset();
    #2 check_all();
    @(negedge clock);
    #2 reset = 1'b1;
    @(posedge clock);
    #1;

    // Load and read, including read of R2 during its own LOAD cycle
    cycle(LOAD, 1, 0, 8'h5A, 1, 2);
    cycle(LOAD, 2, 0, 8'hC3, 1, 2);
    cycle(NOP, 0, 0, 8'h00, 1, 2);
    chk("load_r1", a_r1, 8'h5A);
    chk("load_r2", a_r2, 8'hC3);

    // Arithmetic wrap
    cycle(LOAD, 0, 0, 8'hFF, 0, 0);
    cycle(INC, 0, 0, 8'h00, 0, 0);
    chk("inc_wrap", a_r1, 8'h00);
    cycle(DEC, 0, 0, 8'h00, 0, 0);
    chk("dec_wrap", a_r1, 8'hFF);

    // Swap with a LOAD issued while busy
    cycle(LOAD, 1, 0, 8'h11, 1, 3);
    cycle(LOAD, 3, 0, 8'h33, 1, 3);
    cycle(SWAP, 1, 3, 8'h00, 1, 3);
    chk("swap_busy", 8'(a_busy), 8'h01);
    cycle(LOAD, 1, 0, 8'h77, 1, 3);
    cycle(NOP, 0, 0, 8'h00, 1, 3);
    chk("swap_r1", a_r1, 8'h33);
    chk("swap_r3", a_r2, 8'h11);
    cycle(SWAP, 2, 2, 8'h00, 2, 2);
    cycle(NOP, 0, 0, 8'h00, 2, 2);

    // Stack fill, overflow, LIFO drain, underflow
    for (int i = 0; i < DEPTH; i++) begin
      cycle(LOAD, 1, 0, 8'(8'h10 + i), 1, 0);
      cycle(PUSH, 0, 1, 8'h00, 1, 0);
    end
    cycle(PUSH, 0, 1, 8'h00, 1, 0);
    for (int i = 0; i <= DEPTH; i++) cycle(POP, 0, 0, 8'h00, 0, 1);
    cycle(NOP, 0, 0, 8'h00, 0, 1);

    // Reset between the two swap edges
    cycle(LOAD, 1, 0, 8'h11, 1, 3);
    cycle(LOAD, 3, 0, 8'h33, 1, 3);
    cycle(SWAP, 1, 3, 8'h00, 1, 3);
    do_reset();
    cycle(NOP, 0, 0, 8'h00, 1, 3);
    cycle(NOP, 0, 0, 8'h00, 1, 3);

    // Out-of-range select on the 3-register bank
    cycle(LOAD, 3, 0, 8'hEE, 3, 0);
    cycle(NOP, 0, 0, 8'h00, 3, 2);
    chk("oor_b_read", b_r1, 8'h00);

    // Randomized ops with periodic resets
    for (int n = 0; n < 600; n++) begin
      if (n % 150 == 149) do_reset();
      cycle(3'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), 8'($urandom),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
